video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//   Raster timing source producing hsync/vsync/blanking/DE and pixel counters.
//   Its vsync is the frame heartbeat that the system watchdog monitors.
//   Sits in the video pipeline between the pixel clock-enable divider and the
//   line buffer/scaler. Counters advance only on ce_pix.
//   freeze lets a bench or debugger stall the raster and so starve the watchdog.
// PARAMETERS
//   H_TOTAL       384  pixels per line (incl. blanking)
//   H_ACTIVE      320  visible pixels per line, hcount 0..H_ACTIVE-1
//   H_SYNC_START  336  first hcount with hsync asserted
//   H_SYNC_LEN    32   hsync width in pixels
//   V_TOTAL       264  lines per frame
//   V_ACTIVE      224  visible lines, vcount 0..V_ACTIVE-1
//   V_SYNC_START  236  first vcount with vsync asserted
//   V_SYNC_LEN    8    vsync width in lines
//   HS_POL        1    1 = hsync active-high, 0 = active-low
//   VS_POL        1    1 = vsync active-high, 0 = active-low
// PORTS
//   clk          in   1     system clock (27 MHz)
//   sys_reset    in   1     asynchronous, active-high reset
//   ce_pix       in   1     pixel clock enable, 1-clk pulses
//   freeze       in   1     1 = hold counters and all outputs
//   hcount       out  HW    pixel index, HW = $clog2(H_TOTAL)
//   vcount       out  VW    line index, VW = $clog2(V_TOTAL)
//   hsync        out  1     horizontal sync, polarity per HS_POL
//   vsync        out  1     vertical sync, polarity per VS_POL
//   hblank       out  1     1 when hcount >= H_ACTIVE
//   vblank       out  1     1 when vcount >= V_ACTIVE
//   de           out  1     ~hblank & ~vblank
//   line_start   out  1     1-clk pulse when hcount becomes 0
//   frame_start  out  1     1-clk pulse when (hcount,vcount) becomes (0,0)
// BEHAVIOUR
//   - Reset (async assert, sync release):
//     - hcount = H_TOTAL-1, vcount = V_TOTAL-1.
//     - hsync/vsync inactive (HS_POL/VS_POL applied); hblank = vblank = 1.
//     - de = line_start = frame_start = 0.
//   - Advance: on clk with ce_pix & ~freeze.
//     - hcount wraps H_TOTAL-1 -> 0; vcount increments only on that wrap.
//     - vcount wraps V_TOTAL-1 -> 0.
//     - The first advance after reset yields (0,0) with frame_start = 1.
//   - All outputs are registered and decoded from the NEW counter values in the
//     same edge, so flags and counters are coherent (zero relative latency).
//   - sync windows: active when START <= count < START+LEN. vsync changes only
//     on a line wrap, so its edges coincide with hcount = 0.
//   - line_start/frame_start: exactly one clk wide, asserted only on the advance
//     edge; 0 on every other clk, including ce_pix cycles while frozen.
//   - freeze = 1: counters and level outputs hold their current values; pulses
//     are 0. Release resumes from the held position with no skipped pixel.
//   - ce_pix = 0: identical hold behaviour to freeze.
//   - Reset mid-frame: immediate return to reset values; no partial pulses.
//   - Elaboration checks (assert, fatal):
//     - H_ACTIVE < H_TOTAL and H_SYNC_START+H_SYNC_LEN <= H_TOTAL.
//     - V_ACTIVE < V_TOTAL and V_SYNC_START+V_SYNC_LEN <= V_TOTAL.
//     - H_SYNC_LEN >= 1 and V_SYNC_LEN >= 1.
//   - Counter arithmetic is unsigned at HW/VW bits; wrap is by compare, never
//     by overflow.
// STRUCTURE
//   - Package video_timing_pkg:
//     - Default Neo Geo timing constants (the values above).
//     - Function cnt_w(n) = $clog2(n).
//   - One sub-module, timing_axis #(TOTAL,ACTIVE,SYNC_START,SYNC_LEN,POL), used
//     twice (h, v):
//     - wrap counter with advance input and wrap output;
//     - registered blank/sync decode.
//   - The v instance advance = h wrap & advance.
//   - Top level adds de, line_start and frame_start.
// TESTING
//   - Reset then a constant ce_pix every 4 clk:
//     - first advance gives (0,0) with frame_start = 1 and de = 1;
//     - the next frame_start follows 101376 ce later.
//   - Count over one line: hblank rises at hcount 320; hsync is active for
//     hcount 336..367 (32 ce); line_start fires once per 384 ce.
//   - Count over one frame: vblank rises at vcount 224; vsync is active for
//     vcount 236..243; the vsync rising edge has hcount = 0.
//   - freeze asserted for 1000 ce at hcount 100:
//     - outputs hold and no pulses occur;
//     - after release the next advance gives hcount = 101.
//   - sys_reset pulsed at vcount 150: outputs return to reset values
//     asynchronously; the first ce after release gives frame_start = 1.
//   - HS_POL = 0, VS_POL = 0 build: sync levels are inverted and all other
//     outputs are bit-identical to the default run.

Source files
------------

// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_pkg
//  Description : Shared constants and helpers for the raster timing generator.
//                Holds the default Neo Geo style raster geometry, the flag
//                pair carried by each timing axis, and the counter width
//                helper used to size hcount/vcount.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

  // Default horizontal geometry (pixels)
  localparam int H_TOTAL_DEF      = 384;
  localparam int H_ACTIVE_DEF     = 320;
  localparam int H_SYNC_START_DEF = 336;
  localparam int H_SYNC_LEN_DEF   = 32;

  // Default vertical geometry (lines)
  localparam int V_TOTAL_DEF      = 264;
  localparam int V_ACTIVE_DEF     = 224;
  localparam int V_SYNC_START_DEF = 236;
  localparam int V_SYNC_LEN_DEF   = 8;

  // Default sync polarities: 1 = active-high
  localparam bit HS_POL_DEF = 1'b1;
  localparam bit VS_POL_DEF = 1'b1;

  // Registered level flags produced by one timing axis
  typedef struct packed {
    logic blank;
    logic sync;
  } axis_flags_t;

  // Counter width needed to hold 0..n-1
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage : video_timing_pkg
`default_nettype wire

// File: rtl/video_timing_gen_timing_axis.sv
`default_nettype none
// ============================================================================
//  Module      : timing_axis
//  Description : One raster axis (horizontal or vertical). A wrap counter that
//                steps on adv_i, plus registered blank and sync flags decoded
//                from the counter value being loaded on the same edge, so the
//                flags always describe the count currently on count_o.
//  Ports       : clk          - clock
//                rst          - asynchronous active-high reset
//                adv_i        - advance the counter by one on this edge
//                count_o      - current position, 0..TOTAL-1
//                wrap_o       - adv_i while at TOTAL-1 (combinational)
//                blank_o      - registered, 1 when count_o >= ACTIVE
//                sync_o       - registered sync, active level = POL
//                blank_next_o - blank value being loaded this edge
//  Revision    : 1.0 - initial release
// ============================================================================
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL_DEF,
  parameter int ACTIVE     = H_ACTIVE_DEF,
  parameter int SYNC_START = H_SYNC_START_DEF,
  parameter int SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter bit POL        = 1'b1,
  parameter int W          = cnt_w(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         blank_o,
  output logic         sync_o,
  output logic         blank_next_o
);

  // --------------------------------------------------------------------------
  // Geometry sanity, evaluated at elaboration
  // --------------------------------------------------------------------------
  if (TOTAL < 2) begin : g_chk_total
    $fatal(1, "timing_axis: TOTAL must be at least 2");
  end
  if (!(ACTIVE < TOTAL)) begin : g_chk_active
    $fatal(1, "timing_axis: ACTIVE must be less than TOTAL");
  end
  if (SYNC_START + SYNC_LEN > TOTAL) begin : g_chk_sync_end
    $fatal(1, "timing_axis: sync window extends past TOTAL");
  end
  if (SYNC_LEN < 1) begin : g_chk_sync_len
    $fatal(1, "timing_axis: SYNC_LEN must be at least 1");
  end

  // Compare thresholds carry one extra bit so SYNC_START+SYNC_LEN == 2**W
  // is still representable.
  localparam logic [W-1:0] C_LAST       = W'(TOTAL - 1);
  localparam logic [W:0]   C_ACTIVE     = (W+1)'(ACTIVE);
  localparam logic [W:0]   C_SYNC_START = (W+1)'(SYNC_START);
  localparam logic [W:0]   C_SYNC_END   = (W+1)'(SYNC_START + SYNC_LEN);

  logic [W-1:0] count_q, count_d;
  axis_flags_t  flags_q, flags_d;
  logic         at_last;
  logic         in_sync;

  always_comb begin
    at_last = (count_q == C_LAST);
    count_d = count_q;
    flags_d = flags_q;
    in_sync = 1'b0;
    if (adv_i) begin
      // Wrap by explicit compare; the counter never relies on overflow.
      count_d       = at_last ? '0 : count_q + W'(1);
      in_sync       = ({1'b0, count_d} >= C_SYNC_START) &&
                      ({1'b0, count_d} <  C_SYNC_END);
      flags_d.blank = ({1'b0, count_d} >= C_ACTIVE);
      flags_d.sync  = in_sync ? POL : ~POL;
    end
  end

  // Reset parks the axis on its last position so the first advance lands on 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= C_LAST;
      flags_q.blank <= 1'b1;
      flags_q.sync  <= ~POL;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign count_o      = count_q;
  assign wrap_o       = adv_i & at_last;
  assign blank_o      = flags_q.blank;
  assign sync_o       = flags_q.sync;
  assign blank_next_o = flags_d.blank;

endmodule : timing_axis
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Raster timing source. Produces hsync/vsync, blanking, data
//                enable and pixel/line counters, advancing only on ce_pix
//                while freeze is low. Every output is registered and decoded
//                from the counter values loaded on the same edge, so flags and
//                counters are always coherent.
//  Ports       : clk         - system clock
//                sys_reset   - asynchronous active-high reset
//                ce_pix      - pixel clock enable (1-clk pulses)
//                freeze      - 1 = hold counters and level outputs
//                hcount      - pixel index within the line
//                vcount      - line index within the frame
//                hsync/vsync - sync outputs, active level set by HS_POL/VS_POL
//                hblank      - hcount >= H_ACTIVE
//                vblank      - vcount >= V_ACTIVE
//                de          - visible pixel (~hblank & ~vblank)
//                line_start  - 1-clk pulse when hcount becomes 0
//                frame_start - 1-clk pulse when (hcount,vcount) becomes (0,0)
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_LEN   = V_SYNC_LEN_DEF,
  parameter bit HS_POL       = HS_POL_DEF,
  parameter bit VS_POL       = VS_POL_DEF
) (
  input  logic                        clk,
  input  logic                        sys_reset,
  input  logic                        ce_pix,
  input  logic                        freeze,
  output logic [cnt_w(H_TOTAL)-1:0]   hcount,
  output logic [cnt_w(V_TOTAL)-1:0]   vcount,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        hblank,
  output logic                        vblank,
  output logic                        de,
  output logic                        line_start,
  output logic                        frame_start
);

  localparam int HW = cnt_w(H_TOTAL);
  localparam int VW = cnt_w(V_TOTAL);

  logic adv;
  logic h_wrap, v_wrap;
  logic hblank_next, vblank_next;
  logic de_q, de_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // A frozen raster and a missing pixel enable behave identically.
  assign adv = ce_pix & ~freeze;

  timing_axis #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_SYNC_START),
    .SYNC_LEN   (H_SYNC_LEN),
    .POL        (HS_POL),
    .W          (HW)
  ) u_h_axis (
    .clk          (clk),
    .rst          (sys_reset),
    .adv_i        (adv),
    .count_o      (hcount),
    .wrap_o       (h_wrap),
    .blank_o      (hblank),
    .sync_o       (hsync),
    .blank_next_o (hblank_next)
  );

  // The line counter steps once per horizontal wrap; h_wrap already
  // includes adv, so vsync can only change on a line boundary.
  timing_axis #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_SYNC_START),
    .SYNC_LEN   (V_SYNC_LEN),
    .POL        (VS_POL),
    .W          (VW)
  ) u_v_axis (
    .clk          (clk),
    .rst          (sys_reset),
    .adv_i        (h_wrap),
    .count_o      (vcount),
    .wrap_o       (v_wrap),
    .blank_o      (vblank),
    .sync_o       (vsync),
    .blank_next_o (vblank_next)
  );

  always_comb begin
    // de uses the blank values being loaded this edge so it lines up with
    // the new counters; pulses fire only on the advancing edge.
    de_d          = ~hblank_next & ~vblank_next;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule : video_timing_gen
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Self-checking bench for video_timing_gen. Three instances
//                share stimulus: default geometry, default geometry with both
//                syncs active-low, and a small geometry that makes whole
//                frames short. A reference model tracks the raster as a
//                single linear pixel index per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int A_TOT = H_TOTAL_DEF * V_TOTAL_DEF;
  // Small geometry
  localparam int S_HT = 16, S_HA = 10, S_HSS = 12, S_HSL = 2;
  localparam int S_VT = 12, S_VA = 8,  S_VSS = 9,  S_VSL = 2;
  localparam int C_TOT = S_HT * S_VT;

  typedef logic [38:0] obs_t;

  logic clk = 1'b0;
  logic rst, ce, frz;
  always #5 clk = ~clk;

  logic [8:0] a_h, a_v, b_h, b_v;
  logic [3:0] c_h, c_v;
  logic a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs;
  logic b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs;
  logic c_hs, c_vs, c_hb, c_vb, c_de, c_ls, c_fs;

  video_timing_gen u_dut_a (
    .clk(clk), .sys_reset(rst), .ce_pix(ce), .freeze(frz),
    .hcount(a_h), .vcount(a_v), .hsync(a_hs), .vsync(a_vs),
    .hblank(a_hb), .vblank(a_vb), .de(a_de),
    .line_start(a_ls), .frame_start(a_fs)
  );

  video_timing_gen #(.HS_POL(1'b0), .VS_POL(1'b0)) u_dut_b (
    .clk(clk), .sys_reset(rst), .ce_pix(ce), .freeze(frz),
    .hcount(b_h), .vcount(b_v), .hsync(b_hs), .vsync(b_vs),
    .hblank(b_hb), .vblank(b_vb), .de(b_de),
    .line_start(b_ls), .frame_start(b_fs)
  );

  video_timing_gen #(
    .H_TOTAL(S_HT), .H_ACTIVE(S_HA), .H_SYNC_START(S_HSS), .H_SYNC_LEN(S_HSL),
    .V_TOTAL(S_VT), .V_ACTIVE(S_VA), .V_SYNC_START(S_VSS), .V_SYNC_LEN(S_VSL),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) u_dut_c (
    .clk(clk), .sys_reset(rst), .ce_pix(ce), .freeze(frz),
    .hcount(c_h), .vcount(c_v), .hsync(c_hs), .vsync(c_vs),
    .hblank(c_hb), .vblank(c_vb), .de(c_de),
    .line_start(c_ls), .frame_start(c_fs)
  );

  // ---------------- reference model ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int pA, pC;       // linear pixel index within the frame
  bit m_adv;        // previous edge advanced
  bit m_fresh;      // no advance since reset

  function automatic obs_t expect_obs(input int p, input bit adv, input bit fresh,
                                      input int ht, input int ha, input int hss, input int hsl,
                                      input int vt, input int va, input int vss, input int vsl,
                                      input bit hp, input bit vp);
    int h, v;
    bit hb, vb, hs, vs;
    h  = p % ht;
    v  = p / ht;
    hb = fresh || (h >= ha);
    vb = fresh || (v >= va);
    hs = !fresh && (h >= hss) && (h < hss + hsl);
    vs = !fresh && (v >= vss) && (v < vss + vsl);
    if (vt < 1) v = 0;
    return {16'(h), 16'(v), (hs ? hp : !hp), (vs ? vp : !vp), hb, vb,
            (!hb && !vb), (adv && h == 0), (adv && p == 0)};
  endfunction

  function automatic obs_t obs_a();
    return {16'(a_h), 16'(a_v), a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs};
  endfunction
  function automatic obs_t obs_b();
    return {16'(b_h), 16'(b_v), b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs};
  endfunction
  function automatic obs_t obs_c();
    return {16'(c_h), 16'(c_v), c_hs, c_vs, c_hb, c_vb, c_de, c_ls, c_fs};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (h16,v16,hs,vs,hb,vb,de,ls,fs)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_default"}, obs_a(),
          expect_obs(pA, m_adv, m_fresh, H_TOTAL_DEF, H_ACTIVE_DEF, H_SYNC_START_DEF,
                     H_SYNC_LEN_DEF, V_TOTAL_DEF, V_ACTIVE_DEF, V_SYNC_START_DEF,
                     V_SYNC_LEN_DEF, 1'b1, 1'b1));
    check({tag, "_lowpol"}, obs_b(),
          expect_obs(pA, m_adv, m_fresh, H_TOTAL_DEF, H_ACTIVE_DEF, H_SYNC_START_DEF,
                     H_SYNC_LEN_DEF, V_TOTAL_DEF, V_ACTIVE_DEF, V_SYNC_START_DEF,
                     V_SYNC_LEN_DEF, 1'b0, 1'b0));
    check({tag, "_small"}, obs_c(),
          expect_obs(pC, m_adv, m_fresh, S_HT, S_HA, S_HSS, S_HSL,
                     S_VT, S_VA, S_VSS, S_VSL, 1'b0, 1'b1));
  endtask

  task automatic model_reset();
    pA      = A_TOT - 1;
    pC      = C_TOT - 1;
    m_adv   = 1'b0;
    m_fresh = 1'b1;
  endtask

  // One clock: drive inputs, take the edge, update the model, check all DUTs.
  task automatic step(input bit c, input bit f);
    ce  = c;
    frz = f;
    @(posedge clk);
    m_adv = c && !f;
    if (m_adv) begin
      pA      = (pA + 1) % A_TOT;
      pC      = (pC + 1) % C_TOT;
      m_fresh = 1'b0;
    end
    #2;
    check_all("step");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b0;
    frz = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all("in_reset");
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit ce;
    bit frz;
    int h;
    int v;
    bit ls;
    bit fs;
    bit de;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int hb_rise_h, hs_cnt, hs_first, hs_last, ls_cnt;
    int vb_rise_v, vs_min, vs_max, vs_rise_h;
    int hold_bad, pulse_cnt, guard;
    int fs_idx[$];
    bit prev_b, prev_s;
    obs_t snap;

    tbl[0] = '{ce:0, frz:0, h:383, v:263, ls:0, fs:0, de:0};
    tbl[1] = '{ce:1, frz:0, h:0,   v:0,   ls:1, fs:1, de:1};
    tbl[2] = '{ce:1, frz:1, h:0,   v:0,   ls:0, fs:0, de:1};
    tbl[3] = '{ce:0, frz:0, h:0,   v:0,   ls:0, fs:0, de:1};
    tbl[4] = '{ce:1, frz:0, h:1,   v:0,   ls:0, fs:0, de:1};
    tbl[5] = '{ce:1, frz:0, h:2,   v:0,   ls:0, fs:0, de:1};
    tbl[6] = '{ce:0, frz:1, h:2,   v:0,   ls:0, fs:0, de:1};
    tbl[7] = '{ce:1, frz:0, h:3,   v:0,   ls:0, fs:0, de:1};

    rst = 1'b1;
    ce  = 1'b0;
    frz = 1'b0;
    do_reset();

    // Reset state, explicit constants
    check_int("reset_hcount", int'(a_h), 383);
    check_int("reset_vcount", int'(a_v), 263);
    check_int("reset_hsync_hi", int'(a_hs), 0);
    check_int("reset_hsync_lo", int'(b_hs), 1);
    check_int("reset_de", int'(a_de), 0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].ce, tbl[i].frz);
      check($sformatf("table_%0d", i),
            {16'(a_h), 16'(a_v), 4'b0, a_de, a_ls, a_fs},
            {16'(tbl[i].h), 16'(tbl[i].v), 4'b0, tbl[i].de, tbl[i].ls, tbl[i].fs});
    end

    // One full line, ce every 4 clk
    hb_rise_h = -1; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
    prev_b = a_hb;
    for (int i = 0; i < H_TOTAL_DEF; i++) begin
      step(1'b1, 1'b0);
      if (a_hb && !prev_b) hb_rise_h = int'(a_h);
      prev_b = a_hb;
      if (a_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(a_h);
        hs_last = int'(a_h);
      end
      if (a_ls) ls_cnt++;
      for (int k = 0; k < 3; k++) begin
        step(1'b0, 1'b0);
        if (a_ls) ls_cnt++;
      end
    end
    check_int("hblank_rise_hcount", hb_rise_h, 320);
    check_int("hsync_width_ce", hs_cnt, 32);
    check_int("hsync_first_hcount", hs_first, 336);
    check_int("hsync_last_hcount", hs_last, 367);
    check_int("line_start_per_line", ls_cnt, 1);

    // Two small frames, ce every 4 clk
    vb_rise_v = -1; vs_min = 99; vs_max = -1; vs_rise_h = -1;
    prev_b = c_vb;
    prev_s = c_vs;
    for (int i = 0; i < 2 * C_TOT; i++) begin
      step(1'b1, 1'b0);
      if (c_vb && !prev_b) vb_rise_v = int'(c_v);
      prev_b = c_vb;
      if (c_vs) begin
        if (int'(c_v) < vs_min) vs_min = int'(c_v);
        if (int'(c_v) > vs_max) vs_max = int'(c_v);
        if (!prev_s) vs_rise_h = int'(c_h);
      end
      prev_s = c_vs;
      if (c_fs) fs_idx.push_back(i);
      repeat (3) step(1'b0, 1'b0);
    end
    check_int("vblank_rise_vcount", vb_rise_v, S_VA);
    check_int("vsync_first_line", vs_min, S_VSS);
    check_int("vsync_last_line", vs_max, S_VSS + S_VSL - 1);
    check_int("vsync_rise_hcount", vs_rise_h, 0);
    if (fs_idx.size() < 2) check_int("frame_start_count", fs_idx.size(), 2);
    else check_int("frame_start_interval", fs_idx[1] - fs_idx[0], C_TOT);

    // Freeze for 1000 ce at hcount 100
    do_reset();
    repeat (101) step(1'b1, 1'b0);
    check_int("freeze_entry_hcount", int'(a_h), 100);
    snap = obs_a();
    hold_bad = 0;
    pulse_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b1);
      if (obs_a() !== snap) hold_bad++;
      if (a_ls || a_fs || c_ls || c_fs) pulse_cnt++;
    end
    check_int("freeze_hold_changes", hold_bad, 0);
    check_int("freeze_pulses", pulse_cnt, 0);
    step(1'b1, 1'b0);
    check_int("freeze_release_hcount", int'(a_h), 101);

    // Asynchronous reset mid-frame (small raster at line 6)
    guard = 0;
    while (int'(c_v) != 6 && guard < 4 * C_TOT) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check_int("reach_line_6", int'(c_v), 6);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    check_int("async_reset_vcount", int'(c_v), S_VT - 1);
    ce = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_all("reset_held_ce");
    rst = 1'b0;
    step(1'b1, 1'b0);
    check_int("post_reset_frame_start", int'(a_fs), 1);
    check_int("post_reset_small_fs", int'(c_fs), 1);

    // Randomized enables and freezes against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_video_timing_gen
`default_nettype wire
